// File: rtl/sine_gen.sv
// Direct digital synthesis sine source: a phase accumulator indexes a quarter-wave
// table whose mirror/negate logic rebuilds the full 8-bit offset-binary sine.
module sine_gen #(
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned PHASE_INC   = 858993
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] sine_out
);

  localparam int unsigned IDX_W   = 8;
  localparam int unsigned QIDX_W  = 7;
  localparam int unsigned MID     = 128;

  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]       sine_out_q, sine_out_d;
  logic [IDX_W-1:0]       k_c;
  logic [QIDX_W-1:0]      qidx_c;
  logic [QIDX_W-1:0]      qval_c;

  // round(127*sin(2*pi*i/256)) for i = 0..64
  function automatic logic [QIDX_W-1:0] quarter_lut(input logic [QIDX_W-1:0] i);
    logic [QIDX_W-1:0] q;
    q = '0;
    case (i)
      7'd0:  q = 7'd0;   7'd1:  q = 7'd3;   7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
      7'd4:  q = 7'd12;  7'd5:  q = 7'd16;  7'd6:  q = 7'd19;  7'd7:  q = 7'd22;
      7'd8:  q = 7'd25;  7'd9:  q = 7'd28;  7'd10: q = 7'd31;  7'd11: q = 7'd34;
      7'd12: q = 7'd37;  7'd13: q = 7'd40;  7'd14: q = 7'd43;  7'd15: q = 7'd46;
      7'd16: q = 7'd49;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
      7'd20: q = 7'd60;  7'd21: q = 7'd63;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
      7'd24: q = 7'd71;  7'd25: q = 7'd73;  7'd26: q = 7'd76;  7'd27: q = 7'd78;
      7'd28: q = 7'd81;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd88;
      7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
      7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
      7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd111;
      7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
      7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
      7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
      7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
      7'd60: q = 7'd126; 7'd61: q = 7'd127; 7'd62: q = 7'd127; 7'd63: q = 7'd127;
      7'd64: q = 7'd127;
      default: q = '0;
    endcase
    return q;
  endfunction

  // Odd quadrants read the table backwards; the second half-cycle is negated about midscale.
  always_comb begin
    phase_d    = phase_q + PHASE_WIDTH'(PHASE_INC);
    k_c        = phase_q[PHASE_WIDTH-1 -: IDX_W];
    qidx_c     = k_c[6] ? (7'd64 - {1'b0, k_c[5:0]}) : {1'b0, k_c[5:0]};
    qval_c     = quarter_lut(qidx_c);
    sine_out_d = k_c[7] ? (IDX_W'(MID) - {1'b0, qval_c})
                        : (IDX_W'(MID) + {1'b0, qval_c});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q    <= '0;
      sine_out_q <= IDX_W'(MID);
    end else begin
      phase_q    <= phase_d;
      sine_out_q <= sine_out_d;
    end
  end

  assign sine_out = sine_out_q;

endmodule

// File: tb/tb_sine_gen.sv
// Bench for sine_gen: three instances (default, unit-step and wrap increments) checked
// every clock against a real-arithmetic sine model, with random mid-run resets.
module tb_sine_gen;

  localparam longint unsigned INC_DEF  = 64'd858993;
  localparam longint unsigned INC_STEP = 64'h0100_0000;
  localparam longint unsigned INC_WRAP = 64'h8100_0000;
  localparam real             PI       = 3.141592653589793;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] out_def, out_step, out_wrap;

  int vectors     = 0;
  int miscompares = 0;
  int n_since     = 0;

  always #10 clk = ~clk;

  sine_gen u_def (.clk(clk), .rst(rst), .sine_out(out_def));
  sine_gen #(.PHASE_WIDTH(32), .PHASE_INC(32'h0100_0000)) u_step (.clk(clk), .rst(rst), .sine_out(out_step));
  sine_gen #(.PHASE_WIDTH(32), .PHASE_INC(32'h8100_0000)) u_wrap (.clk(clk), .rst(rst), .sine_out(out_wrap));

  function automatic int ref_lut(input int k);
    real a;
    a = 2.0 * PI * real'(k) / 256.0;
    return 128 + int'(127.0 * $sin(a));
  endfunction

  // Output after the n-th accumulating edge since reset reflects the phase before that edge.
  function automatic int ref_out(input int n, input longint unsigned inc);
    longint unsigned ph;
    if (n == 0) return 128;
    ph = (longint'(n - 1) * inc) & 64'hFFFF_FFFF;
    return int'(ph >> 24);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) n_since++;
    else     n_since = 0;
    #1;
  endtask

  task automatic check_all(input string tag);
    int ed, es, ew;
    ed = (n_since == 0) ? 128 : ref_lut(ref_out(n_since, INC_DEF));
    es = (n_since == 0) ? 128 : ref_lut(ref_out(n_since, INC_STEP));
    ew = (n_since == 0) ? 128 : ref_lut(ref_out(n_since, INC_WRAP));
    chk($sformatf("%s_def@%0d", tag, n_since), 32'(out_def), 32'(ed));
    chk($sformatf("%s_step@%0d", tag, n_since), 32'(out_step), 32'(es));
    chk($sformatf("%s_wrap@%0d", tag, n_since), 32'(out_wrap), 32'(ew));
  endtask

  initial begin
    int sym [256];
    int prev_def, mx, mn, crossings, last_cross, len;

    // Reset held for three edges
    rst = 1'b0;
    repeat (3) begin
      tick();
      check_all("reset");
      chk("reset_phase", 32'(u_def.phase_q), 32'd0);
    end

    // Long run: covers the unit-step landmarks and five default periods
    rst = 1'b1;
    prev_def = 128; mx = 0; mn = 255; crossings = 0; last_cross = -1;
    for (int e = 1; e <= 25100; e++) begin
      tick();
      check_all("run");
      if (e <= 256) sym[e-1] = int'(out_step);
      case (e)
        1:   chk("step_edge1", 32'(out_step), 32'd128);
        2:   begin
               chk("step_edge2", 32'(out_step), 32'd131);
               chk("def_edge2", 32'(out_def), 32'd128);
             end
        65:  chk("step_peak65", 32'(out_step), 32'd255);
        129: chk("step_mid129", 32'(out_step), 32'd128);
        193: chk("step_trough193", 32'(out_step), 32'd1);
        default: ;
      endcase
      if (int'(out_def) > mx) mx = int'(out_def);
      if (int'(out_def) < mn) mn = int'(out_def);
      if (prev_def < 128 && int'(out_def) >= 128) begin
        if (last_cross >= 0)
          chk($sformatf("def_spacing_ok(%0d)", e - last_cross),
              32'((e - last_cross >= 4999) && (e - last_cross <= 5001)), 32'd1);
        last_cross = e;
        crossings++;
      end
      prev_def = int'(out_def);
    end
    chk("def_crossings", 32'(crossings), 32'd5);
    chk("def_peak", 32'(mx), 32'd255);
    chk("def_trough", 32'(mn), 32'd1);

    for (int k = 0; k < 128; k++) begin
      chk($sformatf("sym_sum_k%0d", k), 32'(sym[k] + sym[k+128]), 32'd256);
      chk($sformatf("range_k%0d", k), 32'(sym[k] >= 1 && sym[k] <= 255), 32'd1);
    end

    // Random mid-run resets, each followed by a fresh run checked against the model
    repeat (8) begin
      len = int'($urandom_range(700, 37));
      repeat (len) begin
        tick();
        check_all("pre_rst");
      end
      rst = 1'b0;
      len = int'($urandom_range(3, 1));
      repeat (len) begin
        tick();
        check_all("mid_rst");
        chk("mid_rst_phase", 32'(u_def.phase_q), 32'd0);
      end
      rst = 1'b1;
      for (int e = 1; e <= 300; e++) begin
        tick();
        check_all("post_rst");
        if (e == 65) chk("post_rst_peak", 32'(out_step), 32'd255);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sine_gen.md
SINE_GEN -- requirements
Module: sine_gen

Interface
REQ-001 The parameter PHASE_WIDTH SHALL have default 32 and SHALL set the phase accumulator width in bits.
REQ-002 The parameter PHASE_INC SHALL have default 858993 and SHALL set the per-clock phase increment (10 kHz at 50 MHz clock).
REQ-003 The port clk SHALL be an input of width 1 and SHALL be the single system clock; all state updates on its rising edge.
REQ-004 The port rst SHALL be an input of width 1 and SHALL be a synchronous, active-low reset.
REQ-005 The port sine_out SHALL be an output of width 8 and SHALL carry the registered sine sample, offset-binary (midscale 128).

Function
REQ-006 The module SHALL hold a PHASE_WIDTH-bit phase accumulator that adds PHASE_INC on every rising clk edge while rst=1.
REQ-007 The phase accumulator SHALL wrap modulo 2^PHASE_WIDTH with no saturation and no overflow flag.
REQ-008 The LUT index k SHALL be the top 8 bits of the phase accumulator (phase[PHASE_WIDTH-1:PHASE_WIDTH-8]).
REQ-009 The LUT SHALL return, for k = 0..255, the value 128 + round(127*sin(2*pi*k/256)); the result range is 1..255.
REQ-010 Key LUT values SHALL be: k=0 gives 128; k=1 gives 131; k=64 gives 255; k=128 gives 128; k=192 gives 1.
REQ-011 The LUT SHALL satisfy LUT[128+k] = 256 - LUT[k] and LUT[64+j] = LUT[64-j].
REQ-012 The LUT SHALL be implemented either as a full 256-entry table or as a quarter-wave table (entries 0..64) with mirror/negate logic; the output values SHALL be identical in both cases.
REQ-013 sine_out SHALL be registered: on each rising edge with rst=1, sine_out takes LUT[k] of the phase value held before that edge (one clock latency from phase to output).
REQ-014 The output frequency SHALL be f_clk*PHASE_INC/2^PHASE_WIDTH; with the defaults this is approximately 10 kHz, i.e. 5000 clocks per period.
REQ-015 The module SHALL contain no combinational path from any input to sine_out.

Reset
REQ-016 On a rising edge with rst=0, the phase accumulator SHALL load 0 and sine_out SHALL load 128.
REQ-017 Reset SHALL take precedence over accumulation on the same edge.
REQ-018 Asserting reset mid-waveform SHALL restart the waveform from phase 0 with no residual state.
REQ-019 Before the first clock edge, sine_out is undefined; the bench SHALL apply reset for at least 2 clocks.
REQ-020 On the 1st edge after reset release, sine_out SHALL be 128 (LUT[0]); on the 2nd edge it SHALL be LUT[PHASE_INC >> (PHASE_WIDTH-8)].

Verification
REQ-021 Reset hold: rst=0 for 3 clocks -> sine_out=128 and phase=0 on every edge.
REQ-022 Unit step: PHASE_INC=2^24 (one LUT step per clock), release reset -> outputs 128, 131, ... reaching 255 on the 65th edge after release, 128 on the 129th, 1 on the 193rd, and a period of exactly 256 clocks.
REQ-023 Symmetry sweep: PHASE_INC=2^24 over 256 clocks -> every sample is within 1..255 and LUT[128+k] + LUT[k] = 256 for all k.
REQ-024 Default frequency: defaults with 50 MHz clk for 0.5 ms -> 5 full periods, each peak 255 and trough 1, with upward midscale crossings spaced 5000 +/- 1 clocks.
REQ-025 Mid-run reset: apply rst=0 for 1 clock at an arbitrary phase, then release -> sine_out=128 on the reset edge and the waveform repeats the post-reset sequence of REQ-022 exactly.
REQ-026 Wrap-around: PHASE_INC=2^31+2^24 -> sample index advances by 129 per clock mod 256, and the outputs match the LUT formula of REQ-009 with no glitches at the wrap.
